// File: rtl/stream_mux_pkg.sv
// Shared constants and the round-robin search helper for the N-channel stream mux.
package stream_mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    localparam int MAX_NCH = 64;
    localparam int IDXW    = 6;

    typedef struct packed {
        logic            found;
        logic [IDXW-1:0] idx;
    } rr_pick_t;

    // First set bit of valid_vec at or after ptr, wrapping modulo nch.
    function automatic rr_pick_t next_rr(input int nch, input logic [IDXW-1:0] ptr,
                                         input logic [MAX_NCH-1:0] valid_vec);
        rr_pick_t r;
        int       k;
        r.found = 1'b0;
        r.idx   = '0;
        for (int j = MAX_NCH - 1; j >= 0; j--) begin
            if (j < nch) begin
                k = (int'(ptr) + j) % nch;
                if (valid_vec[IDXW'(k)]) begin
                    r.found = 1'b1;
                    r.idx   = IDXW'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_mux_nch_if.sv
// Producer/consumer bundle of the N-channel stream mux.
interface stream_mux_nch_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8
);
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [SELW-1:0]      sel;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;

    modport master (
        output sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/stream_mux_nch_rr_pick.sv
// Combinational first-valid search starting at a rotating pointer.
module rr_pick
    import stream_mux_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = 2
) (
    input  logic [SELW-1:0] ptr,
    input  logic [NCH-1:0]  valid,
    output logic            found,
    output logic [SELW-1:0] idx
);
    logic [MAX_NCH-1:0] vec;
    rr_pick_t           pick;

    always_comb begin
        vec          = '0;
        vec[NCH-1:0] = valid;
        pick         = next_rr(NCH, IDXW'(ptr), vec);
        found        = pick.found && (int'(pick.idx) < NCH);
        idx          = pick.idx[SELW-1:0];
    end

endmodule

// File: rtl/stream_mux_nch.sv
// N-channel stream multiplexer: external-select or round-robin arbitration into one
// registered output word with valid/ready on every port.
module stream_mux_nch
    import stream_mux_pkg::*;
#(
    parameter int  NCH   = 4,
    parameter int  WIDTH = 8,
    parameter int  MODE  = MODE_SEL,
    localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input logic             clk,
    input logic             rst,
    stream_mux_nch_if.slave bus
);
    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [SELW-1:0]  ch_p1;
    logic [SELW-1:0]  chosen;
    logic             have_ch;
    logic             load_en;
    logic             xfer;
    logic [NCH-1:0]   rdy;
    logic [WIDTH-1:0] src;

    assign load_en = !vld_p1 || bus.out_ready;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SELW-1:0] ptr;

            rr_pick #(.NCH(NCH), .SELW(SELW)) u_pick (
                .ptr   (ptr),
                .valid (bus.in_valid),
                .found (have_ch),
                .idx   (chosen)
            );

            // Pointer moves only on an actual transfer, so stalls keep fairness intact.
            always_ff @(posedge clk) begin
                if (rst)
                    ptr <= '0;
                else if (xfer)
                    ptr <= (chosen == SELW'(NCH - 1)) ? '0 : chosen + 1'b1;
            end
        end else begin : g_sel
            assign chosen  = bus.sel;
            assign have_ch = int'(bus.sel) < NCH;
        end
    endgenerate

    always_comb begin
        rdy = '0;
        src = '0;
        for (int i = 0; i < NCH; i++) begin
            if (chosen == SELW'(i)) begin
                rdy[i] = !rst && load_en && have_ch;
                src    = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(rdy & bus.in_valid);

    // Stage p1: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
        end else if (load_en) begin
            vld_p1 <= xfer;
            if (xfer) begin
                data_p1 <= src;
                ch_p1   <= chosen;
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_ch    = ch_p1;

endmodule

// File: tb/tb_stream_mux_nch.sv
// Scoreboard bench: three mux variants (4ch select, 3ch select, 4ch round-robin) on shared stimulus.
module tb_stream_mux_nch;

    localparam int ND = 3;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] ch;
    } word_t;

    logic clk;
    logic rst;

    logic [1:0]  sel_d  [ND];
    logic [3:0]  iv_d   [ND];
    logic [31:0] dat_d  [ND];
    logic        ordy_d [ND];
    logic [3:0]  ir_o   [ND];
    logic        ov_o   [ND];
    logic [7:0]  od_o   [ND];
    logic [1:0]  oc_o   [ND];

    int    n_vec = 0;
    int    n_err = 0;
    int    m_ptr [ND];
    bit    m_ov  [ND];
    word_t sb    [ND][$];
    bit    after_rst;
    bit    mon_en = 0;

    stream_mux_nch_if #(.NCH(4), .WIDTH(8)) if0 ();
    stream_mux_nch_if #(.NCH(3), .WIDTH(8)) if1 ();
    stream_mux_nch_if #(.NCH(4), .WIDTH(8)) if2 ();

    stream_mux_nch #(.NCH(4), .WIDTH(8), .MODE(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    stream_mux_nch #(.NCH(3), .WIDTH(8), .MODE(0)) u1 (.clk(clk), .rst(rst), .bus(if1));
    stream_mux_nch #(.NCH(4), .WIDTH(8), .MODE(1)) u2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.sel = sel_d[0];
    assign if0.in_valid = iv_d[0];
    assign if0.in_data = dat_d[0];
    assign if0.out_ready = ordy_d[0];
    assign if1.sel = sel_d[1];
    assign if1.in_valid = iv_d[1][2:0];
    assign if1.in_data = dat_d[1][23:0];
    assign if1.out_ready = ordy_d[1];
    assign if2.sel = sel_d[2];
    assign if2.in_valid = iv_d[2];
    assign if2.in_data = dat_d[2];
    assign if2.out_ready = ordy_d[2];

    assign ir_o[0] = if0.in_ready;
    assign ir_o[1] = {1'b0, if1.in_ready};
    assign ir_o[2] = if2.in_ready;
    assign ov_o[0] = if0.out_valid;
    assign ov_o[1] = if1.out_valid;
    assign ov_o[2] = if2.out_valid;
    assign od_o[0] = if0.out_data;
    assign od_o[1] = if1.out_data;
    assign od_o[2] = if2.out_data;
    assign oc_o[0] = if0.out_ch;
    assign oc_o[1] = if1.out_ch;
    assign oc_o[2] = if2.out_ch;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nch_of(int k);
        return (k == 1) ? 3 : 4;
    endfunction

    function automatic int mode_of(int k);
        return (k == 2) ? 1 : 0;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Which channel the rules pick this cycle, -1 if none.
    function automatic int ref_choice(int k);
        int n;
        n = nch_of(k);
        if (mode_of(k) == 0)
            return (int'(sel_d[k]) < n) ? int'(sel_d[k]) : -1;
        for (int j = 0; j < n; j++) begin
            int c;
            c = (m_ptr[k] + j) % n;
            if (iv_d[k][c]) return c;
        end
        return -1;
    endfunction

    task automatic drive(bit r, logic [1:0] s, logic [3:0] v, bit ordy, logic [31:0] d);
        rst = r;
        for (int k = 0; k < ND; k++) begin
            sel_d[k]  = s;
            iv_d[k]   = v;
            ordy_d[k] = ordy;
            dat_d[k]  = d;
        end
    endtask

    // Check the cycle's combinational view, advance one clock, then update the model.
    task automatic tick();
        int g  [ND];
        bit le [ND];
        #1;
        for (int k = 0; k < ND; k++) begin
            int       c;
            logic [3:0] er;
            c     = ref_choice(k);
            le[k] = !m_ov[k] || ordy_d[k];
            er    = (!rst && le[k] && c >= 0) ? (4'b0001 << c) : 4'b0000;
            chk($sformatf("u%0d in_ready", k), 32'(ir_o[k]), 32'(er));
            chk($sformatf("u%0d out_valid", k), 32'(ov_o[k]), 32'(m_ov[k]));
            if (after_rst) begin
                chk($sformatf("u%0d rst out_data", k), 32'(od_o[k]), 32'h0);
                chk($sformatf("u%0d rst out_ch", k), 32'(oc_o[k]), 32'h0);
            end
            g[k] = (!rst && le[k] && c >= 0 && iv_d[k][c]) ? c : -1;
        end
        @(posedge clk);
        for (int k = 0; k < ND; k++) begin
            if (rst) begin
                m_ov[k]  = 1'b0;
                m_ptr[k] = 0;
                sb[k].delete();
            end else if (le[k]) begin
                m_ov[k] = (g[k] >= 0);
                if (g[k] >= 0) begin
                    sb[k].push_back('{d: dat_d[k][g[k]*8 +: 8], ch: 2'(g[k])});
                    m_ptr[k] = (g[k] + 1) % nch_of(k);
                end
            end
        end
        after_rst = rst;
        #1;
    endtask

    // Monitor: pops an expected word on every output handshake, and checks hold during stalls.
    bit         prev_stall [ND];
    bit         prev_rst;
    logic [7:0] prev_od    [ND];
    logic [1:0] prev_oc    [ND];

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < ND; k++) begin
                if (prev_stall[k] && !prev_rst) begin
                    chk($sformatf("u%0d hold valid", k), 32'(ov_o[k]), 32'h1);
                    chk($sformatf("u%0d hold data", k), 32'(od_o[k]), 32'(prev_od[k]));
                    chk($sformatf("u%0d hold ch", k), 32'(oc_o[k]), 32'(prev_oc[k]));
                end
                if (ov_o[k] === 1'b1 && ordy_d[k]) begin
                    if (sb[k].size() == 0) begin
                        chk($sformatf("u%0d unexpected word", k), 32'(od_o[k]), 32'hFFFF_FFFF);
                    end else begin
                        word_t w;
                        w = sb[k].pop_front();
                        chk($sformatf("u%0d out_data", k), 32'(od_o[k]), 32'(w.d));
                        chk($sformatf("u%0d out_ch", k), 32'(oc_o[k]), 32'(w.ch));
                    end
                end
                prev_stall[k] = (ov_o[k] === 1'b1) && !ordy_d[k];
                prev_od[k]    = od_o[k];
                prev_oc[k]    = oc_o[k];
            end
            prev_rst = rst;
        end
    end

    initial begin
        for (int k = 0; k < ND; k++) begin
            m_ptr[k] = 0;
            m_ov[k]  = 1'b0;
            prev_stall[k] = 1'b0;
        end
        prev_rst = 1'b1;
        drive(1'b1, 2'd0, 4'hF, 1'b1, $urandom);
        @(posedge clk);
        #1;
        after_rst = 1'b1;
        mon_en    = 1'b1;
        tick();
        tick();

        for (int s = 0; s < 4; s++) begin
            drive(1'b0, 2'(s), 4'hF, 1'b1, 32'h4433_2211);
            tick();
        end
        for (int s = 0; s < 3; s++) begin
            drive(1'b0, 2'd3, 4'hF, 1'b1, 32'h4433_2211);
            tick();
        end

        for (int s = 0; s < 4; s++) begin
            drive(1'b0, 2'd1, 4'b1010, 1'b1, $urandom);
            tick();
        end
        drive(1'b0, 2'd1, 4'b0010, 1'b1, $urandom);
        tick();
        drive(1'b0, 2'd0, 4'b0001, 1'b1, $urandom);
        tick();

        drive(1'b0, 2'd2, 4'hF, 1'b1, $urandom);
        tick();
        for (int s = 0; s < 3; s++) begin
            drive(1'b0, 2'(s), 4'hF, 1'b0, $urandom);
            tick();
        end
        drive(1'b1, 2'd1, 4'hF, 1'b0, $urandom);
        tick();
        for (int s = 0; s < 3; s++) begin
            drive(1'b0, 2'd0, 4'hF, 1'b1, $urandom);
            tick();
        end

        for (int s = 0; s < 400; s++) begin
            drive($urandom_range(0, 49) == 0, 2'($urandom_range(0, 3)), 4'($urandom),
                  $urandom_range(0, 3) != 0, $urandom);
            tick();
        end

        for (int s = 0; s < 4; s++) begin
            drive(1'b0, 2'd0, 4'h0, 1'b1, $urandom);
            tick();
        end
        @(negedge clk);
        for (int k = 0; k < ND; k++)
            chk($sformatf("u%0d leftover words", k), 32'(sb[k].size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_mux_nch.md
Name: stream_mux_nch

Overview:
- Parametrised N-channel, W-bit stream multiplexer with a registered output stage and valid/ready handshake on every port.
- Successor to the team's fixed 4:1 single-bit combinational mux.
- Adds selectable arbitration: external select, or internal round-robin.
- Sits between multiple producer streams and a single downstream consumer.

Parameters:
NCH, 4, number of input channels (>= 2)
WIDTH, 8, data bits per channel
MODE, 0, 0 = external select via sel, 1 = internal round-robin (sel ignored)
SELW, $clog2(NCH), width of sel/out_ch (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
sel  input  SELW  channel select, MODE 0 only
in_valid  input  NCH  per-channel valid
in_ready  output  NCH  per-channel ready
in_data  input  NCH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
out_valid  output  1  output register holds a word
out_ready  input  1  downstream accepts
out_data  output  WIDTH  registered data
out_ch  output  SELW  source channel of out_data

Behaviour:
- Reset is synchronous; rst high at a clock edge produces:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=0.
  - Any held word is dropped.
  - in_ready is all zero while rst is high.
- load_en = !out_valid || out_ready. The output register may accept a new word in the same cycle the old one leaves, giving full throughput of 1 word/cycle.
- Choosing the channel:
  - MODE 0: chosen = sel. If sel >= NCH, no channel is chosen and all in_ready = 0.
  - MODE 1: chosen = first i with in_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo NCH.
- in_ready[i] = load_en && (chosen == i); all other bits are 0.
  - MODE 0: in_ready does not depend on in_valid.
  - MODE 1: in_ready depends combinationally on in_valid.
  - At most one in_ready bit is high in any cycle.
- Transfer on channel i: in_valid[i] && in_ready[i] at a clock edge. The next cycle shows out_valid=1, out_data=in_data[i], out_ch=i. Latency is 1 cycle.
- No transfer && out_ready: out_valid goes to 0. out_data and out_ch keep their last values.
- out_valid && !out_ready: out_valid, out_data and out_ch stay stable (hold).
- Round-robin pointer (MODE 1):
  - After a transfer from channel i, ptr = (i+1) mod NCH.
  - With no transfer, ptr is unchanged.
  - A stalled output (load_en=0) does not move ptr.
- MODE 0 with sel changing while the output is stalled: no effect until load_en=1. The sel value sampled in the load cycle decides the source.
- NCH not a power of two: the wrap in the ptr search uses explicit modulo. It never selects index >= NCH.

Decomposition:
- Package stream_mux_pkg holds:
  - MODE_SEL=0 and MODE_RR=1 constants.
  - A function next_rr(ptr, valid_vec) that returns the chosen index and a found flag.
- One sub-module is natural: rr_pick, a combinational first-valid-from-pointer search over NCH bits. It is instantiated only when MODE=1.
- The output register stays in the top module.

Test Plan (NCH=4, WIDTH=8):
- Reset: hold rst for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=4'b0000 during reset.
- MODE 0 walk: sel=0..3 in turn, in_data={8'h44,8'h33,8'h22,8'h11}, all valid, out_ready=1 -> one cycle after each select, out_data=11,22,33,44 with out_ch=0..3; in_ready is one-hot on sel.
- MODE 0 out-of-range: NCH=3, sel=3, all valid -> in_ready=3'b000, out_valid falls to 0 after the current word drains.
- MODE 1 fairness: all four channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, one word/cycle.
- MODE 1 sparse and wrap:
  - Only channels 1 and 3 valid, ptr=0 -> out_ch 1,3,1,3.
  - Then only channel 0 valid with ptr=2 -> search wraps, out_ch=0.
- Backpressure and reset mid-operation:
  - out_ready=0 for 3 cycles with out_valid=1 -> out_data and out_ch are held, in_ready=0, ptr unchanged.
  - Assert rst during the stall -> the next cycle shows out_valid=0 and ptr=0; the first grant afterwards is to channel 0.
